// File: rtl/adc_ctrl_pkg.sv
// Shared types and default-width constants for the miniasic ADC conversion/trim controller.
// The top recomputes its widths from its own parameters; these constants describe the default build.
package adc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        EVAL
    } cal_state_t;

    localparam int ADC_DATA_W   = 11;
    localparam int ADC_AVG_LOG2 = 4;
    localparam int ADC_MID      = 1 << (ADC_DATA_W - 1);
    localparam int ACC_W        = ADC_DATA_W + ADC_AVG_LOG2;

endpackage

// File: rtl/adc_conv_trim_ctrl_clk_div.sv
// Conversion-clock divider: free-runs while run=1 and parks at phase 0 otherwise.
// strobe marks the last system clock of each ADC period, where the ADC output is sampled.
module adc_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic adc_clk_o,
    output logic strobe
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_reg;
    logic             adc_clk_reg;

    assign strobe    = run && (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign adc_clk_o = adc_clk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            adc_clk_reg <= 1'b0;
        end else begin
            adc_clk_reg <= run && (cnt_reg < CNT_W'(CLK_DIV / 2));
            if (!run || strobe)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/adc_conv_trim_ctrl.sv
// miniasic ADC controller: conversion clock, sample capture, manual trim and trim-calibration sweep.
// Optional ADC_CAL_ABORT_EN adds cal_abort, which cancels a sweep and restores the previous trim.
module adc_conv_trim_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W   = 11,
    parameter int TRIM_W   = 3,
    parameter int CLK_DIV  = 4,
    parameter int AVG_LOG2 = 4,
    parameter int SETTLE_N = 8,
    parameter int TRIM_RST = 4
) (
    input  logic              clk_adc,
    input  logic              rst_adc,
    input  logic              enable,
    input  logic              cal_start,
    input  logic              trim_wr,
    input  logic [TRIM_W-1:0] trim_wdata,
    input  logic [DATA_W-1:0] adc_data,
`ifdef ADC_CAL_ABORT_EN
    input  logic              cal_abort,
`endif
    output logic              adc_clk_o,
    output logic [TRIM_W-1:0] trm_o,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic              cal_busy,
    output logic              cal_done,
    output logic [TRIM_W-1:0] cal_trim
);

    localparam int ACC_BITS = DATA_W + AVG_LOG2;
    localparam int SC_W     = $clog2(SETTLE_N + 1);
    localparam logic [DATA_W-1:0] MID_V = DATA_W'(1 << (DATA_W - 1));

    cal_state_t          state_reg, state_next;
    logic [TRIM_W-1:0]   code_reg, code_next;
    logic [TRIM_W-1:0]   trm_reg, trm_next;
    logic [TRIM_W-1:0]   best_reg, best_next, best_sel;
    logic [DATA_W-1:0]   best_err_reg, best_err_next;
    logic [ACC_BITS-1:0] acc_reg, acc_next;
    logic [AVG_LOG2-1:0] acc_cnt_reg, acc_cnt_next;
    logic [TRIM_W-1:0]   cal_trim_reg, cal_trim_next;
    logic                cal_done_reg, cal_done_next;
    logic [SC_W-1:0]     settle_cnt_reg;
    logic                enable_d_reg;
    logic                sample_valid_reg;
    logic [DATA_W-1:0]   sample_data_reg;
    logic [DATA_W-1:0]   avg, err;
    logic                settle_restart, settle_clr, run, strobe, settled;
`ifdef ADC_CAL_ABORT_EN
    logic [TRIM_W-1:0]   trm_saved_reg;
`endif

    assign cal_busy     = (state_reg != IDLE);
    assign run          = enable || cal_busy;
    assign settled      = (settle_cnt_reg == SC_W'(SETTLE_N));
    assign trm_o        = trm_reg;
    assign cal_trim     = cal_trim_reg;
    assign cal_done     = cal_done_reg;
    assign sample_valid = sample_valid_reg;
    assign sample_data  = sample_data_reg;

    adc_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk_adc),
        .rst       (rst_adc),
        .run       (run),
        .adc_clk_o (adc_clk_o),
        .strobe    (strobe)
    );

    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        code_next      = code_reg;
        trm_next       = trm_reg;
        best_next      = best_reg;
        best_err_next  = best_err_reg;
        acc_next       = acc_reg;
        acc_cnt_next   = acc_cnt_reg;
        cal_trim_next  = cal_trim_reg;
        cal_done_next  = 1'b0;
        settle_restart = 1'b0;
        best_sel       = best_reg;
        avg            = acc_reg[ACC_BITS-1:AVG_LOG2];
        err            = (avg >= MID_V) ? (avg - MID_V) : (MID_V - avg);
        case (state_reg)
            IDLE: begin
                if (cal_start) begin
                    state_next     = SETTLE;
                    code_next      = '0;
                    trm_next       = '0;
                    best_next      = '0;
                    best_err_next  = '1;
                    settle_restart = 1'b1;
                end else if (trim_wr) begin
                    trm_next = trim_wdata;
                end
            end
            SETTLE: begin
                if (strobe && settle_cnt_reg == SC_W'(SETTLE_N - 1)) begin
                    state_next   = ACCUM;
                    acc_next     = '0;
                    acc_cnt_next = '0;
                end
            end
            ACCUM: begin
                if (strobe) begin
                    acc_next     = acc_reg + ACC_BITS'(adc_data);
                    acc_cnt_next = acc_cnt_reg + 1'b1;
                    if (acc_cnt_reg == '1)
                        state_next = EVAL;
                end
            end
            EVAL: begin
                // Strict less-than keeps the lowest code among equal errors.
                if (err < best_err_reg) begin
                    best_next     = code_reg;
                    best_err_next = err;
                    best_sel      = code_reg;
                end
                if (code_reg == '1) begin
                    trm_next      = best_sel;
                    cal_trim_next = best_sel;
                    cal_done_next = 1'b1;
                    state_next    = IDLE;
                end else begin
                    code_next  = code_reg + 1'b1;
                    trm_next   = code_reg + 1'b1;
                    state_next = SETTLE;
                end
                settle_restart = 1'b1;
            end
            default: state_next = IDLE;
        endcase
`ifdef ADC_CAL_ABORT_EN
        if (cal_abort && state_reg != IDLE) begin
            state_next     = IDLE;
            trm_next       = trm_saved_reg;
            cal_trim_next  = cal_trim_reg;
            cal_done_next  = 1'b0;
            settle_restart = 1'b1;
        end
`endif
        settle_clr = settle_restart || !run || (trm_next != trm_reg)
                     || (enable && !enable_d_reg && state_reg == IDLE);
    end

    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            code_reg         <= '0;
            trm_reg          <= TRIM_W'(TRIM_RST);
            best_reg         <= '0;
            best_err_reg     <= '1;
            acc_reg          <= '0;
            acc_cnt_reg      <= '0;
            cal_trim_reg     <= TRIM_W'(TRIM_RST);
            cal_done_reg     <= 1'b0;
            settle_cnt_reg   <= '0;
            enable_d_reg     <= 1'b0;
            sample_valid_reg <= 1'b0;
            sample_data_reg  <= '0;
        end else begin
            code_reg     <= code_next;
            trm_reg      <= trm_next;
            best_reg     <= best_next;
            best_err_reg <= best_err_next;
            acc_reg      <= acc_next;
            acc_cnt_reg  <= acc_cnt_next;
            cal_trim_reg <= cal_trim_next;
            cal_done_reg <= cal_done_next;
            enable_d_reg <= enable;
            // A capture taken under a settled trim is still delivered even if the trim changes on that edge.
            if (settle_clr)
                settle_cnt_reg <= '0;
            else if (strobe && !settled)
                settle_cnt_reg <= settle_cnt_reg + 1'b1;
            if (strobe && enable && state_reg == IDLE && settled) begin
                sample_valid_reg <= 1'b1;
                sample_data_reg  <= adc_data;
            end else begin
                sample_valid_reg <= 1'b0;
            end
        end
    end

`ifdef ADC_CAL_ABORT_EN
    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc)
            trm_saved_reg <= TRIM_W'(TRIM_RST);
        else if (state_reg == IDLE && cal_start)
            trm_saved_reg <= trm_reg;
    end
`endif

endmodule

// File: doc/adc_conv_trim_ctrl.md
Name: adc_conv_trim_ctrl

Overview:
- Controller for the 11-bit miniasic ADC.
- Generates the ADC conversion clock, captures the parallel output bits, and drives the 3-bit trim code.
- Runs a trim-calibration sweep: with inputs shorted externally, it picks the trim code whose averaged output is closest to mid-scale.
- Sits in the core between the ADC pad signals (clk_adc, out_bits*, trm*) and the digital sample consumer / config logic.

Parameters:
- DATA_W, 11, ADC output width.
- TRIM_W, 3, trim code width; the sweep covers codes 0..2^TRIM_W-1.
- CLK_DIV, 4, system clocks per ADC clock period; even, >=2.
- AVG_LOG2, 4, log2 of samples averaged per trim point.
- SETTLE_N, 8, ADC samples discarded after every trim change or enable rise.
- TRIM_RST, 4, trim code value at reset.

Ports:
- clk_adc  in  1  system clock.
- rst_adc  in  1  asynchronous active-high reset.
- enable  in  1  run continuous conversion.
- cal_start  in  1  one-cycle pulse; starts a calibration sweep.
- trim_wr  in  1  manual trim write strobe.
- trim_wdata  in  TRIM_W  manual trim value.
- adc_data  in  DATA_W  ADC out_bits[10:0].
- adc_clk_o  out  1  conversion clock to ADC.
- trm_o  out  TRIM_W  trim code to ADC.
- sample_valid  out  1  one-cycle pulse; sample_data valid.
- sample_data  out  DATA_W  captured sample.
- cal_busy  out  1  calibration in progress.
- cal_done  out  1  one-cycle pulse at sweep end.
- cal_trim  out  TRIM_W  best code from last sweep.

Behaviour:
- Reset values: adc_clk_o=0, trm_o=TRIM_RST, sample_valid=0, sample_data=0, cal_busy=0, cal_done=0, cal_trim=TRIM_RST. The divider counter and FSM both reset to IDLE/0.
- Divider:
  - Counter cnt runs 0..CLK_DIV-1 only when enable or cal_busy; otherwise it holds 0 and adc_clk_o stays 0.
  - adc_clk_o=1 for cnt<CLK_DIV/2, else 0. adc_clk_o is registered (glitch-free).
  - Capture strobe is asserted on the cycle where cnt==CLK_DIV-1. adc_data is registered on that cycle.
- Discard counter:
  - Counts captures. It is cleared on an enable 0->1 transition, on any trm_o change, and on run stop.
  - The first SETTLE_N captures after a clear are discarded.
- Normal mode (enable=1, cal_busy=0):
  - Each non-discarded capture produces sample_valid=1 one cycle after the strobe, with sample_data = captured value.
- Manual trim:
  - trim_wr with cal_busy=0 loads trm_o on the next edge.
  - trim_wr is ignored while cal_busy=1.
- Calibration FSM states:
  - IDLE: cal_start -> SETTLE. On entry, code=0, trm_o=0, best_err=all ones, best=0, cal_busy=1.
  - SETTLE: after SETTLE_N captures -> ACCUM, with acc=0.
  - ACCUM: add each capture into acc (width DATA_W+AVG_LOG2, cannot overflow). After 2^AVG_LOG2 captures -> EVAL.
  - EVAL (1 cycle):
    - avg = acc>>AVG_LOG2; err = |avg - 2^(DATA_W-1)| (DATA_W bits).
    - If err<best_err: best=code, best_err=err. Strict compare, so ties keep the lower code.
    - If code==max: trm_o=best, cal_trim=best, cal_done=1 -> IDLE with cal_busy=0. Normal sampling resumes if enable=1, re-settling first.
    - Otherwise code++, trm_o=code+1 -> SETTLE.
- sample_valid is held 0 while cal_busy=1.
- cal_start is ignored while cal_busy=1.
- enable toggling during calibration has no effect on the sweep.
- rst_adc asserted mid-sweep returns everything to the reset values immediately; trm_o=TRIM_RST, not a partial result.

Optional Feature:
- Macro: ADC_CAL_ABORT_EN.
- With the macro:
  - Adds input cal_abort (1 bit).
  - cal_abort=1 while cal_busy -> IDLE on the next edge. trm_o is restored to the value held before cal_start, cal_trim is unchanged, and cal_done is not pulsed.
  - cal_abort and cal_start on the same cycle in IDLE: the start wins.
- Without the macro: no port; a sweep always runs to completion.

Decomposition:
- Package adc_ctrl_pkg holds:
  - the cal FSM state enum (IDLE, SETTLE, ACCUM, EVAL);
  - the constants ADC_MID=2^(DATA_W-1) and ACC_W=DATA_W+AVG_LOG2.
- One sub-module, adc_clk_div: divider counter, adc_clk_o, and the capture strobe.
- The FSM, accumulator and discard counter stay in the top.

Test Plan:
- Reset then enable=1 with default parameters, adc_data=0x2A5:
  - adc_clk_o has period 4 clocks and 50% duty.
  - The first 8 captures are silent.
  - sample_valid then pulses every 4 clocks with sample_data=0x2A5.
- trim_wr=1, trim_wdata=6 while running:
  - trm_o=6 next edge.
  - 8 samples are discarded, then valid pulses resume.
  - The same write during a sweep leaves trm_o unchanged.
- Calibration where the ADC model returns 0x400+40-12*trm:
  - err per code is 40, 28, 16, 4, 8, 20, 32, 44.
  - cal_trim=3, trm_o=3, cal_done pulses once.
  - Sweep length = 8*(8+16) captures.
- Ties: model err=10 for codes 2 and 5 and larger elsewhere -> cal_trim=2.
- rst_adc asserted during ACCUM of code 5:
  - All outputs return to reset values; trm_o=4.
  - A new cal_start runs the full sweep from code 0.
- ADC_CAL_ABORT_EN defined, trm_o=6, cal_start, then cal_abort at code 3:
  - trm_o=6, cal_busy=0, no cal_done.
